fir_extclk_s_axil_regs: RTL and testbench

AXI4-Lite slave register file that answers the master VIP on the FIR filter IP's S00_AXI port. It holds four 32-bit software-visible registers at offsets 0x0, 0x4, 0x8 and 0xC, and exports them to the filter datapath. It also emits a one-cycle write pulse per register. The bus-functional bench's write-then-readback sequence (values 1..4) must pass against this block unchanged.

---
 rtl/fir_extclk_s_axil_regs.sv | 186 ++++++++++++++++++
 tb/tb_fir_extclk_s_axil_regs.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_extclk_s_axil_regs.sv
// fir_extclk_s_axil_regs
// AXI4-Lite slave holding four 32-bit control registers for the FIR datapath.
// AW and W are buffered independently; a three-state write FSM commits the
// buffered beat, pulses reg_wr_pulse and returns an OKAY response. The read
// channel is independent and answers with one cycle of latency.
module fir_extclk_s_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   // write address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                        s_axi_awprot,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   // write data channel
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   // write response channel
   output logic [1:0]                        s_axi_bresp,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   // read address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                        s_axi_arprot,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   // read data channel
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   // datapath side
   output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
   output logic [3:0]                        reg_wr_pulse
);

   localparam int NB = C_S_AXI_DATA_WIDTH / 8;

   // IDLE: collecting AW/W; COMMIT: cycle in which the new value and pulse
   // are visible and bvalid is up; RESP: waiting for bready.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COMMIT = 2'd1,
      ST_RESP   = 2'd2
   } wr_state_t;

   wr_state_t                            r_state;
   wr_state_t                            w_state_nxt;

   logic                                 r_aw_full;
   logic [1:0]                           r_aw_sel;
   logic                                 r_w_full;
   logic [C_S_AXI_DATA_WIDTH-1:0]        r_wdata;
   logic [NB-1:0]                        r_wstrb;

   logic                                 r_bvalid;
   logic                                 r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0]        r_rdata;
   logic [3:0]                           r_wr_pulse;
   logic [3:0][C_S_AXI_DATA_WIDTH-1:0]   r_regs;

   logic                                 w_aw_hs;
   logic                                 w_w_hs;
   logic                                 w_ar_hs;
   logic                                 w_b_done;
   logic                                 w_commit;
   logic                                 w_unused;

   // Protection bits and the byte offset inside a register carry no meaning here.
   assign w_unused = &{1'b0, s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Readies are forced low while reset is held so no beat is taken during reset.
   assign s_axi_awready = !reset && !r_aw_full && (r_state == ST_IDLE);
   assign s_axi_wready  = !reset && !r_w_full  && (r_state == ST_IDLE);
   assign s_axi_arready = !reset && !r_rvalid;

   assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_w_hs   = s_axi_wvalid  && s_axi_wready;
   assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
   assign w_b_done = r_bvalid && s_axi_bready;

   assign s_axi_bvalid = r_bvalid;
   assign s_axi_bresp  = 2'b00;
   assign s_axi_rvalid = r_rvalid;
   assign s_axi_rdata  = r_rdata;
   assign s_axi_rresp  = 2'b00;
   assign reg_out      = r_regs;
   assign reg_wr_pulse = r_wr_pulse;

   // Write FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Write FSM next state; w_commit fires on the edge that enters COMMIT.
   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned (no latch).
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_aw_full && r_w_full) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: w_state_nxt = w_b_done ? ST_IDLE : ST_RESP;
         ST_RESP:   if (w_b_done) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Write-address holding register; released by the B handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_aw_full <= 1'b0;
         r_aw_sel  <= 2'd0;
      end else if (w_b_done) begin
         r_aw_full <= 1'b0;
      end else if (w_aw_hs) begin
         r_aw_full <= 1'b1;
         r_aw_sel  <= s_axi_awaddr[3:2];
      end
   end

   // Write-data holding register; released by the B handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_w_full <= 1'b0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else if (w_b_done) begin
         r_w_full <= 1'b0;
      end else if (w_w_hs) begin
         r_w_full <= 1'b1;
         r_wdata  <= s_axi_wdata;
         r_wstrb  <= s_axi_wstrb;
      end
   end

   // Write response valid: raised at commit, dropped on bready.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         r_bvalid <= 1'b0;
      else if (w_commit) r_bvalid <= 1'b1;
      else if (w_b_done) r_bvalid <= 1'b0;
   end

   // Register file update under byte strobes, plus the one-cycle commit pulse.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: this register file is reset because software and the datapath
      // rely on known zero contents; a plain data RAM would not be.
      if (reset) begin
         r_regs     <= '0;
         r_wr_pulse <= 4'b0000;
      end else begin
         r_wr_pulse <= w_commit ? (4'b0001 << r_aw_sel) : 4'b0000;
         if (w_commit) begin
            for (int i = 0; i < NB; i++) begin
               if (r_wstrb[i]) r_regs[r_aw_sel][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   // Read channel: capture on AR handshake, hold until rready.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= r_regs[s_axi_araddr[3:2]];
      end else if (r_rvalid && s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_extclk_s_axil_regs.sv
// tb_fir_extclk_s_axil_regs
// Directed and randomized AXI4-Lite transactions against a reference model
// of four byte-strobed registers.
module tb_fir_extclk_s_axil_regs;

   logic          clock;
   logic          reset;
   logic [3:0]    s_axi_awaddr;
   logic [2:0]    s_axi_awprot;
   logic          s_axi_awvalid;
   logic          s_axi_awready;
   logic [31:0]   s_axi_wdata;
   logic [3:0]    s_axi_wstrb;
   logic          s_axi_wvalid;
   logic          s_axi_wready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid;
   logic          s_axi_bready;
   logic [3:0]    s_axi_araddr;
   logic [2:0]    s_axi_arprot;
   logic          s_axi_arvalid;
   logic          s_axi_arready;
   logic [31:0]   s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rvalid;
   logic          s_axi_rready;
   logic [127:0]  reg_out;
   logic [3:0]    reg_wr_pulse;

   int total = 0;
   int bad   = 0;
   logic [31:0] m_regs [4];

   fir_extclk_s_axil_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (s_axi_arprot),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .reg_out       (reg_out),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop if something hangs despite the bounded waits.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the active edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Merge data into old under byte enables: byte i taken from data if strb[i].
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] mask;
      mask = 32'h0;
      for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
      return (old & ~mask) | (data & mask);
   endfunction

   function automatic logic [127:0] model_flat();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   task automatic wait_ready(input string tag, input bit need_aw, input bit need_w, input bit need_ar);
      int n;
      n = 0;
      while (((need_aw && !s_axi_awready) || (need_w && !s_axi_wready) ||
              (need_ar && !s_axi_arready)) && n < 50) begin
         tick();
         n++;
      end
      check(tag, (n < 50), 1'b1);
   endtask

   // Full write with bready held high; checks commit timing and response.
   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int sel;
      sel = int'(addr[3:2]);
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      s_axi_bready  = 1'b1;
      wait_ready("wr_ready_wait", 1'b1, 1'b1, 1'b0);
      tick();                                   // AW and W accepted
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      check("wr_no_early_pulse", reg_wr_pulse, 4'b0000);
      tick();                                   // commit edge
      m_regs[sel] = merge(m_regs[sel], data, strb);
      check("wr_pulse", reg_wr_pulse, 4'b0001 << sel);
      check("wr_reg_out", reg_out, model_flat());
      check("wr_bvalid", s_axi_bvalid, 1'b1);
      check("wr_bresp", s_axi_bresp, 2'b00);
      tick();                                   // B handshake
      check("wr_bvalid_clear", s_axi_bvalid, 1'b0);
      check("wr_pulse_clear", reg_wr_pulse, 4'b0000);
      check("wr_ready_back", {s_axi_awready, s_axi_wready}, 2'b11);
   endtask

   // Full read with rready held high; checks 1-cycle latency and data.
   task automatic do_read(input logic [3:0] addr);
      int sel;
      sel = int'(addr[3:2]);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b1;
      wait_ready("rd_ready_wait", 1'b0, 1'b0, 1'b1);
      tick();                                   // AR accepted
      s_axi_arvalid = 1'b0;
      check("rd_rvalid", s_axi_rvalid, 1'b1);
      check("rd_rresp", s_axi_rresp, 2'b00);
      check("rd_rdata", s_axi_rdata, m_regs[sel]);
      tick();
      check("rd_rvalid_clear", s_axi_rvalid, 1'b0);
      check("rd_arready_back", s_axi_arready, 1'b1);
   endtask

   initial begin
      logic [31:0] held;
      reset = 1'b1;
      s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;

      // 1. reset values
      #50;
      check("rst_readies_low", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      #50;
      reset = 1'b0;
      #1;
      check("rst_readies_high", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      check("rst_reg_out", reg_out, 128'h0);
      check("rst_outputs", {s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, reg_wr_pulse}, 10'h0);
      check("rst_rdata", s_axi_rdata, 32'h0);
      tick();

      // 2. write/readback 1..4
      for (int i = 0; i < 4; i++) do_write(4'(4 * i), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) do_read(4'(4 * i));

      // 3. W arrives three cycles before AW
      s_axi_wdata  = 32'h55;
      s_axi_wstrb  = 4'hF;
      s_axi_wvalid = 1'b1;
      s_axi_bready = 1'b1;
      wait_ready("wfirst_wready_wait", 1'b0, 1'b1, 1'b0);
      tick();
      s_axi_wvalid = 1'b0;
      check("wfirst_wready_low", s_axi_wready, 1'b0);
      check("wfirst_awready_high", s_axi_awready, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("wfirst_reg2_unchanged", reg_out[95:64], m_regs[2]);
         check("wfirst_no_pulse", reg_wr_pulse, 4'b0000);
      end
      tick();
      s_axi_awaddr  = 4'h8;
      s_axi_awvalid = 1'b1;
      check("wfirst_aw_ready", s_axi_awready, 1'b1);
      tick();                                   // AW accepted
      s_axi_awvalid = 1'b0;
      check("wfirst_reg2_pre", reg_out[95:64], m_regs[2]);
      tick();                                   // commit
      m_regs[2] = 32'h55;
      check("wfirst_pulse", reg_wr_pulse, 4'b0100);
      check("wfirst_reg2", reg_out[95:64], 32'h55);
      tick();
      check("wfirst_bdone", s_axi_bvalid, 1'b0);

      // 4. byte strobes on reg1 via unaligned address
      do_write(4'h6, 32'hAABBCCDD, 4'b0101);
      check("strobe_literal", reg_out[63:32], 32'h00BB00DD);

      // strobe 0: handshake and pulse, no change
      do_write(4'hC, 32'hDEADBEEF, 4'b0000);

      // 5. B backpressure with a second write waiting
      s_axi_bready  = 1'b0;
      s_axi_awaddr  = 4'hC;
      s_axi_wdata   = 32'h1234_5678;
      s_axi_wstrb   = 4'hF;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      wait_ready("bp_ready_wait", 1'b1, 1'b1, 1'b0);
      tick();
      s_axi_awaddr = 4'h4;
      s_axi_wdata  = 32'hCAFE_F00D;
      tick();                                   // commit of first write
      m_regs[3] = 32'h1234_5678;
      check("bp_first_reg", reg_out, model_flat());
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_bvalid_held", s_axi_bvalid, 1'b1);
         check("bp_readies_low", {s_axi_awready, s_axi_wready}, 2'b00);
         check("bp_no_second", reg_wr_pulse, 4'b0000);
      end
      s_axi_bready = 1'b1;
      tick();                                   // B handshake
      check("bp_bdone", s_axi_bvalid, 1'b0);
      check("bp_readies_back", {s_axi_awready, s_axi_wready}, 2'b11);
      tick();                                   // second write accepted
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      check("bp_second_taken", {s_axi_awready, s_axi_wready}, 2'b00);
      tick();
      m_regs[1] = 32'hCAFE_F00D;
      check("bp_second_pulse", reg_wr_pulse, 4'b0010);
      check("bp_second_reg", reg_out, model_flat());
      tick();

      // R backpressure
      s_axi_rready  = 1'b0;
      s_axi_araddr  = 4'hC;
      s_axi_arvalid = 1'b1;
      check("rbp_arready", s_axi_arready, 1'b1);
      tick();
      s_axi_arvalid = 1'b0;
      held = m_regs[3];
      for (int i = 0; i < 5; i++) begin
         check("rbp_rvalid_held", s_axi_rvalid, 1'b1);
         check("rbp_rdata_stable", s_axi_rdata, held);
         check("rbp_arready_low", s_axi_arready, 1'b0);
         tick();
      end
      s_axi_rready = 1'b1;
      tick();
      check("rbp_rdone", {s_axi_rvalid, s_axi_arready}, 2'b01);

      // 6a. reset while a B response is pending
      s_axi_bready  = 1'b0;
      s_axi_awaddr  = 4'h0;
      s_axi_wdata   = 32'h77;
      s_axi_wstrb   = 4'hF;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      wait_ready("rstp_ready_wait", 1'b1, 1'b1, 1'b0);
      tick();
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      tick();
      check("rstp_bvalid_pending", s_axi_bvalid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
      check("rstp_bvalid_drop", s_axi_bvalid, 1'b0);
      check("rstp_reg_out_drop", reg_out, 128'h0);
      check("rstp_readies_low", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      tick();
      tick();
      reset = 1'b0;
      s_axi_bready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rstp_no_bresp", {s_axi_bvalid, reg_wr_pulse}, 5'b0);
      end

      // 6b. AR on the commit edge of a write to the same register
      do_write(4'h0, 32'h1, 4'hF);
      s_axi_awaddr  = 4'h0;
      s_axi_wdata   = 32'h9;
      s_axi_wstrb   = 4'hF;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      s_axi_bready  = 1'b1;
      wait_ready("same_ready_wait", 1'b1, 1'b1, 1'b0);
      tick();                                   // AW/W accepted
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_araddr  = 4'h0;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b1;
      check("same_arready", s_axi_arready, 1'b1);
      tick();                                   // commit and AR on one edge
      s_axi_arvalid = 1'b0;
      check("same_pulse", reg_wr_pulse, 4'b0001);
      check("same_rvalid", s_axi_rvalid, 1'b1);
      check("same_rdata_old", s_axi_rdata, 32'h1);
      m_regs[0] = 32'h9;
      tick();
      do_read(4'h0);

      // randomized writes and reads against the model
      for (int i = 0; i < 24; i++) begin
         do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
         do_read(4'($urandom_range(0, 15)));
      end
      check("final_reg_out", reg_out, model_flat());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
